// File: rtl/uart_pkg.sv
// Shared UART definitions: data width and the tx-queue launch FSM state encoding.
package uart_pkg;

   localparam int UART_DATA_W = 32;

   typedef enum logic [1:0] {
      TXQ_IDLE      = 2'd0,
      TXQ_LAUNCH    = 2'd1,
      TXQ_WAIT_BUSY = 2'd2,
      TXQ_WAIT_DONE = 2'd3
   } txq_state_t;

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock word FIFO holding the storage, wrap-around pointers and fill level.
module uart_sync_fifo
   import uart_pkg::*;
#(
   parameter int DEPTH = 8,
   parameter int LW    = $clog2(DEPTH) + 1
) (
   input  logic                   i_clk,
   input  logic                   i_rst,
   input  logic [UART_DATA_W-1:0] i_wr_data,
   input  logic                   i_wr_en,
   input  logic                   i_rd_en,
   output logic [UART_DATA_W-1:0] o_rd_data,
   output logic                   o_full,
   output logic                   o_empty,
   output logic [LW-1:0]          o_level,
   output logic                   o_overflow
);

   localparam int AW = $clog2(DEPTH);

   logic [UART_DATA_W-1:0] r_mem [DEPTH];
   logic [AW-1:0]          r_wr_ptr;
   logic [AW-1:0]          r_rd_ptr;
   logic [LW-1:0]          r_level;
   logic                   r_overflow;
   logic                   w_full;
   logic                   w_empty;
   logic                   w_push;
   logic                   w_pop;

   assign w_full  = (r_level == LW'(DEPTH));
   assign w_empty = (r_level == '0);
   assign w_push  = i_wr_en & ~w_full;
   assign w_pop   = i_rd_en & ~w_empty;

   always_ff @(posedge i_clk) begin
      if (w_push && !i_rst) begin
         r_mem[r_wr_ptr] <= i_wr_data;
      end
   end

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_level    <= '0;
         r_overflow <= 1'b0;
      end else begin
         r_overflow <= i_wr_en & w_full;
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + AW'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + AW'(1);
         end
         case ({w_push, w_pop})
            2'b10:   r_level <= r_level + LW'(1);
            2'b01:   r_level <= r_level - LW'(1);
            default: r_level <= r_level;
         endcase
      end
   end

   assign o_rd_data  = r_mem[r_rd_ptr];
   assign o_full     = w_full;
   assign o_empty    = w_empty;
   assign o_level    = r_level;
   assign o_overflow = r_overflow;

endmodule

// File: rtl/uart_tx_queue.sv
// Word queue feeding a UART transmitter through a start/busy handshake.
// Define UART_TXQ_TIMEOUT_EN to abandon launches the transmitter never acknowledges.
//
// state     | meaning
// IDLE      | waiting for a queued word and an idle transmitter
// LAUNCH    | tx_start asserted for one cycle, head word on tx_data
// WAIT_BUSY | waiting for the transmitter to raise tx_busy
// WAIT_DONE | transmitter busy, waiting for tx_busy to fall
module uart_tx_queue
   import uart_pkg::*;
#(
   parameter int DEPTH         = 8,
   parameter int START_TIMEOUT = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [UART_DATA_W-1:0] wr_data,
   input  logic                   wr_en,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] level,
   output logic                   overflow,
   output logic [UART_DATA_W-1:0] tx_data,
   output logic                   tx_start,
   input  logic                   tx_busy,
   output logic                   timeout_err
);

   localparam int LW = $clog2(DEPTH) + 1;

   txq_state_t             r_state;
   txq_state_t             w_next;
   logic                   w_pop;
   logic                   w_tmo;
   logic [UART_DATA_W-1:0] w_head;
   logic [UART_DATA_W-1:0] r_tx_data;

   uart_sync_fifo #(
      .DEPTH (DEPTH),
      .LW    (LW)
   ) u_fifo (
      .i_clk      (clk),
      .i_rst      (rst),
      .i_wr_data  (wr_data),
      .i_wr_en    (wr_en),
      .i_rd_en    (w_pop),
      .o_rd_data  (w_head),
      .o_full     (full),
      .o_empty    (empty),
      .o_level    (level),
      .o_overflow (overflow)
   );

`ifdef UART_TXQ_TIMEOUT_EN
   localparam int TW = (START_TIMEOUT > 1) ? $clog2(START_TIMEOUT) : 1;

   logic [TW-1:0] r_tmo_cnt;

   // Loaded during LAUNCH so the first WAIT_BUSY cycle sees START_TIMEOUT-1.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_tmo_cnt <= '0;
      end else if (r_state == TXQ_LAUNCH) begin
         r_tmo_cnt <= TW'(START_TIMEOUT - 1);
      end else if (r_state == TXQ_WAIT_BUSY && r_tmo_cnt != '0) begin
         r_tmo_cnt <= r_tmo_cnt - TW'(1);
      end
   end

   assign w_tmo = (r_state == TXQ_WAIT_BUSY) && !tx_busy && (r_tmo_cnt == '0);
`else
   assign w_tmo = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= TXQ_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         TXQ_IDLE: begin
            if (!empty && !tx_busy) begin
               w_next = TXQ_LAUNCH;
            end
         end
         TXQ_LAUNCH: begin
            w_next = TXQ_WAIT_BUSY;
         end
         TXQ_WAIT_BUSY: begin
            if (tx_busy) begin
               w_next = TXQ_WAIT_DONE;
            end else if (w_tmo) begin
               w_next = TXQ_IDLE;
            end
         end
         TXQ_WAIT_DONE: begin
            if (!tx_busy) begin
               w_next = TXQ_IDLE;
            end
         end
         default: w_next = TXQ_IDLE;
      endcase
   end

   always_comb begin
      w_pop       = (r_state == TXQ_IDLE) && !empty && !tx_busy;
      tx_start    = (r_state == TXQ_LAUNCH);
      timeout_err = w_tmo;
   end

   // Captured on the pop edge and held until the next pop.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_tx_data <= '0;
      end else if (w_pop) begin
         r_tx_data <= w_head;
      end
   end

   assign tx_data = r_tx_data;

endmodule

// File: tb/tb_uart_tx_queue.sv
// Directed self-checking bench for uart_tx_queue (timeout checks follow UART_TXQ_TIMEOUT_EN).
module tb_uart_tx_queue;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] wr_data;
   logic        wr_en;
   logic        full;
   logic        empty;
   logic [3:0]  level;
   logic        overflow;
   logic [31:0] tx_data;
   logic        tx_start;
   logic        tx_busy;
   logic        timeout_err;

   logic        hold_busy = 1'b0;
   logic        model_en = 1'b0;
   logic        model_busy = 1'b0;
   int          busy_delay = 1;
   int          busy_len = 1;

   int          n_checks = 0;
   int          n_pass = 0;

   logic [31:0] got[$];
   int          start_cyc[$];
   int          cyc = 0;
   int          ovf_cnt = 0;
   int          tmo_cnt = 0;
   int          tmo_cyc = -1;
   int          busy_launch = 0;
   int          b2b = 0;
   logic        prev_start = 1'b0;

   assign tx_busy = hold_busy | model_busy;

   always #5 clk = ~clk;

   uart_tx_queue #(
      .DEPTH         (8),
      .START_TIMEOUT (16)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .wr_data     (wr_data),
      .wr_en       (wr_en),
      .full        (full),
      .empty       (empty),
      .level       (level),
      .overflow    (overflow),
      .tx_data     (tx_data),
      .tx_start    (tx_start),
      .tx_busy     (tx_busy),
      .timeout_err (timeout_err)
   );

   // Event monitor: sampled on the falling edge.
   initial begin
      forever begin
         @(negedge clk);
         cyc++;
         if (tx_start === 1'b1) begin
            got.push_back(tx_data);
            start_cyc.push_back(cyc);
            if (tx_busy) busy_launch++;
            if (prev_start) b2b++;
         end
         prev_start = (tx_start === 1'b1);
         if (overflow === 1'b1) ovf_cnt++;
         if (timeout_err === 1'b1) begin
            tmo_cnt++;
            tmo_cyc = cyc;
         end
      end
   end

   // Transmitter model: busy rises busy_delay cycles after tx_start, stays busy_len cycles.
   initial begin
      int st;
      int left;
      st = 0;
      left = 0;
      forever begin
         @(negedge clk);
         if (!model_en) begin
            model_busy = 1'b0;
            st = 0;
            left = 0;
         end else begin
            if (left > 0) begin
               left--;
               if (left == 0) model_busy = 1'b0;
            end else if (st > 0) begin
               st--;
               if (st == 0) begin
                  model_busy = 1'b1;
                  left = busy_len;
               end
            end
            if (tx_start === 1'b1) st = busy_delay;
         end
      end
   end

   task automatic step(input int n);
      repeat (n) @(negedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      wr_en = 1'b0;
      wr_data = '0;
      step(2);
      rst = 1'b0;
      got.delete();
      start_cyc.delete();
      ovf_cnt = 0;
      tmo_cnt = 0;
      tmo_cyc = -1;
      busy_launch = 0;
      b2b = 0;
   endtask

   task automatic test_reset();
      hold_busy = 1'b0;
      model_en = 1'b0;
      do_reset();
      n_checks++; if (empty !== 1'b1) $display("FAIL reset_empty: got %b want 1", empty); else n_pass++;
      n_checks++; if (full !== 1'b0) $display("FAIL reset_full: got %b want 0", full); else n_pass++;
      n_checks++; if (level !== 4'd0) $display("FAIL reset_level: got %0d want 0", level); else n_pass++;
      n_checks++; if (overflow !== 1'b0) $display("FAIL reset_overflow: got %b want 0", overflow); else n_pass++;
      n_checks++; if (tx_start !== 1'b0) $display("FAIL reset_tx_start: got %b want 0", tx_start); else n_pass++;
      n_checks++; if (tx_data !== 32'h0) $display("FAIL reset_tx_data: got %h want 0", tx_data); else n_pass++;
      n_checks++; if (timeout_err !== 1'b0) $display("FAIL reset_timeout_err: got %b want 0", timeout_err); else n_pass++;
   endtask

   task automatic test_single();
      do_reset();
      model_en = 1'b1;
      busy_delay = 3;
      busy_len = 20;
      wr_en = 1'b1;
      wr_data = 32'hA5A5A5A5;
      step(1);
      wr_en = 1'b0;
      n_checks++; if (tx_start !== 1'b0) $display("FAIL single_early_start: got %b want 0", tx_start); else n_pass++;
      n_checks++; if (level !== 4'd1) $display("FAIL single_level1: got %0d want 1", level); else n_pass++;
      step(1);
      n_checks++; if (tx_start !== 1'b1) $display("FAIL single_latency: got %b want 1", tx_start); else n_pass++;
      n_checks++; if (tx_data !== 32'hA5A5A5A5) $display("FAIL single_tx_data: got %h want a5a5a5a5", tx_data); else n_pass++;
      step(30);
      n_checks++; if (got.size() != 1) $display("FAIL single_start_count: got %0d want 1", got.size()); else n_pass++;
      n_checks++; if (empty !== 1'b1) $display("FAIL single_empty_end: got %b want 1", empty); else n_pass++;
      n_checks++; if (tx_data !== 32'hA5A5A5A5) $display("FAIL single_tx_data_hold: got %h want a5a5a5a5", tx_data); else n_pass++;
   endtask

   task automatic test_burst();
      do_reset();
      model_en = 1'b0;
      hold_busy = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         wr_en = 1'b1;
         wr_data = 32'(i);
         step(1);
      end
      wr_en = 1'b0;
      n_checks++; if (full !== 1'b1) $display("FAIL burst_full: got %b want 1", full); else n_pass++;
      n_checks++; if (level !== 4'd8) $display("FAIL burst_level: got %0d want 8", level); else n_pass++;
      n_checks++; if (got.size() != 0) $display("FAIL burst_no_launch_busy: got %0d starts want 0", got.size()); else n_pass++;
   endtask

   task automatic test_overflow();
      int w;
      logic seen_bad;
      wr_en = 1'b1;
      wr_data = 32'h12345678;
      step(1);
      wr_en = 1'b0;
      n_checks++; if (overflow !== 1'b1) $display("FAIL ovf_pulse: got %b want 1", overflow); else n_pass++;
      n_checks++; if (level !== 4'd8) $display("FAIL ovf_level: got %0d want 8", level); else n_pass++;
      step(1);
      n_checks++; if (overflow !== 1'b0) $display("FAIL ovf_pulse_end: got %b want 0", overflow); else n_pass++;
      busy_delay = 1;
      busy_len = 2;
      model_en = 1'b1;
      hold_busy = 1'b0;
      w = 0;
      while (got.size() < 8 && w < 300) begin
         step(1);
         w++;
      end
      step(10);
      n_checks++; if (got.size() != 8) $display("FAIL burst_drain_count: got %0d want 8", got.size()); else n_pass++;
      for (int i = 0; i < 8; i++) begin
         n_checks++;
         if (i >= got.size() || got[i] !== 32'(i + 1))
            $display("FAIL burst_order[%0d]: got %h want %h", i, (i < got.size()) ? got[i] : 32'hx, 32'(i + 1));
         else n_pass++;
      end
      seen_bad = 1'b0;
      foreach (got[i]) if (got[i] === 32'h12345678) seen_bad = 1'b1;
      n_checks++; if (seen_bad !== 1'b0) $display("FAIL ovf_word_emitted: got %b want 0", seen_bad); else n_pass++;
      n_checks++; if (ovf_cnt != 1) $display("FAIL ovf_count: got %0d want 1", ovf_cnt); else n_pass++;
      n_checks++; if (b2b != 0 || busy_launch != 0) $display("FAIL burst_spacing: got b2b=%0d busy_launch=%0d want 0/0", b2b, busy_launch); else n_pass++;
      n_checks++; if (empty !== 1'b1) $display("FAIL burst_empty_end: got %b want 1", empty); else n_pass++;
   endtask

   task automatic test_simul_push_pop();
      int w;
      do_reset();
      model_en = 1'b0;
      hold_busy = 1'b1;
      wr_en = 1'b1;
      wr_data = 32'hB0;
      step(1);
      wr_data = 32'hB1;
      step(1);
      wr_en = 1'b0;
      n_checks++; if (level !== 4'd2) $display("FAIL simul_pre_level: got %0d want 2", level); else n_pass++;
      busy_delay = 1;
      busy_len = 2;
      model_en = 1'b1;
      hold_busy = 1'b0;
      wr_en = 1'b1;
      wr_data = 32'hB2;
      step(1);
      wr_en = 1'b0;
      n_checks++; if (level !== 4'd2) $display("FAIL simul_level: got %0d want 2", level); else n_pass++;
      n_checks++; if (tx_start !== 1'b1 || tx_data !== 32'hB0) $display("FAIL simul_launch: got start=%b data=%h want 1/b0", tx_start, tx_data); else n_pass++;
      w = 0;
      while (got.size() < 3 && w < 100) begin
         step(1);
         w++;
      end
      step(5);
      n_checks++;
      if (got.size() != 3 || got[1] !== 32'hB1 || got[2] !== 32'hB2)
         $display("FAIL simul_order: got %0d words want b0,b1,b2", got.size());
      else n_pass++;
   endtask

   task automatic test_wrap();
      int sent;
      do_reset();
      hold_busy = 1'b0;
      busy_delay = 1;
      busy_len = 1;
      model_en = 1'b1;
      sent = 0;
      for (int c = 0; c < 600 && got.size() < 20; c++) begin
         if (sent < 20 && full === 1'b0) begin
            wr_en = 1'b1;
            wr_data = 32'(sent);
            sent++;
         end else begin
            wr_en = 1'b0;
         end
         step(1);
      end
      wr_en = 1'b0;
      step(6);
      n_checks++; if (got.size() != 20) $display("FAIL wrap_count: got %0d want 20", got.size()); else n_pass++;
      for (int i = 0; i < 20; i++) begin
         n_checks++;
         if (i >= got.size() || got[i] !== 32'(i))
            $display("FAIL wrap_order[%0d]: got %h want %h", i, (i < got.size()) ? got[i] : 32'hx, 32'(i));
         else n_pass++;
      end
      n_checks++; if (level !== 4'd0 || empty !== 1'b1) $display("FAIL wrap_level_end: got level=%0d empty=%b want 0/1", level, empty); else n_pass++;
      n_checks++; if (ovf_cnt != 0 || b2b != 0) $display("FAIL wrap_clean: got ovf=%0d b2b=%0d want 0/0", ovf_cnt, b2b); else n_pass++;
   endtask

   task automatic test_timeout();
      do_reset();
      hold_busy = 1'b0;
      model_en = 1'b0;
      wr_en = 1'b1;
      wr_data = 32'hC0;
      step(1);
      wr_data = 32'hC1;
      step(1);
      wr_en = 1'b0;
`ifdef UART_TXQ_TIMEOUT_EN
      begin
         int w;
         w = 0;
         while (start_cyc.size() < 2 && w < 100) begin
            step(1);
            w++;
         end
         n_checks++;
         if (start_cyc.size() < 2) begin
            $display("FAIL tmo_relaunch_wait: got %0d starts want 2", start_cyc.size());
         end else begin
            n_pass++;
            n_checks++; if (tmo_cyc != start_cyc[0] + 16) $display("FAIL tmo_pulse_cycle: got %0d want %0d", tmo_cyc, start_cyc[0] + 16); else n_pass++;
            n_checks++; if (start_cyc[1] != start_cyc[0] + 18) $display("FAIL tmo_next_launch: got %0d want %0d", start_cyc[1], start_cyc[0] + 18); else n_pass++;
            n_checks++; if (got[1] !== 32'hC1) $display("FAIL tmo_next_word: got %h want c1", got[1]); else n_pass++;
         end
         n_checks++; if (tmo_cnt != 1) $display("FAIL tmo_count: got %0d want 1", tmo_cnt); else n_pass++;
      end
`else
      step(60);
      n_checks++; if (tmo_cnt != 0) $display("FAIL tmo_disabled_pulse: got %0d want 0", tmo_cnt); else n_pass++;
      n_checks++; if (got.size() != 1) $display("FAIL tmo_disabled_hang: got %0d starts want 1", got.size()); else n_pass++;
      n_checks++; if (level !== 4'd1) $display("FAIL tmo_disabled_level: got %0d want 1", level); else n_pass++;
`endif
      do_reset();
   endtask

   task automatic test_reset_mid();
      int w;
      int n;
      do_reset();
      hold_busy = 1'b0;
      busy_delay = 1;
      busy_len = 200;
      model_en = 1'b1;
      for (int i = 0; i < 4; i++) begin
         wr_en = 1'b1;
         wr_data = 32'hD0 + 32'(i);
         step(1);
      end
      wr_en = 1'b0;
      w = 0;
      while (tx_busy !== 1'b1 && w < 20) begin
         step(1);
         w++;
      end
      step(2);
      n_checks++; if (level !== 4'd3 || tx_busy !== 1'b1) $display("FAIL rstmid_pre: got level=%0d busy=%b want 3/1", level, tx_busy); else n_pass++;
      rst = 1'b1;
      model_en = 1'b0;
      step(1);
      rst = 1'b0;
      n_checks++; if (level !== 4'd0 || empty !== 1'b1) $display("FAIL rstmid_level: got level=%0d empty=%b want 0/1", level, empty); else n_pass++;
      n_checks++; if (tx_data !== 32'h0) $display("FAIL rstmid_tx_data: got %h want 0", tx_data); else n_pass++;
      n = got.size();
      step(50);
      n_checks++; if (got.size() != n) $display("FAIL rstmid_no_start: got %0d starts want %0d", got.size(), n); else n_pass++;
   endtask

   initial begin
      rst = 1'b1;
      wr_en = 1'b0;
      wr_data = '0;
      test_reset();
      test_single();
      test_burst();
      test_overflow();
      test_simul_push_pop();
      test_wrap();
      test_timeout();
      test_reset_mid();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/uart_tx_queue.md
UART_TX_QUEUE -- requirements
Module: uart_tx_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 8, meaning word capacity of the queue (power of 2, 2..64).
REQ-002 SHALL have parameter START_TIMEOUT, default 16, meaning cycles allowed for tx_busy to rise after tx_start.
REQ-003 SHALL have one clock and synchronous active-high reset: clk  input  1  rising-edge clock; rst  input  1  synchronous active-high reset.
REQ-004 SHALL have wr_data  input  32  word to enqueue.
REQ-005 SHALL have wr_en  input  1  enqueue request, one word per cycle.
REQ-006 SHALL have full  output  1  queue holds DEPTH words.
REQ-007 SHALL have empty  output  1  queue holds 0 words.
REQ-008 SHALL have level  output  $clog2(DEPTH)+1  current word count.
REQ-009 SHALL have overflow  output  1  one-cycle pulse when wr_en is dropped because full=1.
REQ-010 SHALL have tx_data  output  32  word presented to the downstream transmitter.
REQ-011 SHALL have tx_start  output  1  one-cycle launch pulse to the transmitter.
REQ-012 SHALL have tx_busy  input  1  transmitter busy flag.
REQ-013 SHALL have timeout_err  output  1  one-cycle pulse when a launch is abandoned.

Function
REQ-014 SHALL accept a write iff wr_en=1 and full=0 at the clock edge; wr_en=1 with full=1 drops the word and pulses overflow in the next cycle.
REQ-015 SHALL be FIFO-ordered, with read/write pointers wrapping modulo DEPTH and no word loss or duplication across wrap.
REQ-016 SHALL run FSM states IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE.
REQ-017 SHALL go IDLE->LAUNCH when empty=0 and tx_busy=0, popping the head word into tx_data on that edge.
REQ-018 SHALL hold tx_start=1 exactly while in LAUNCH (one cycle), then go LAUNCH->WAIT_BUSY.
REQ-019 SHALL go WAIT_BUSY->WAIT_DONE on tx_busy=1, then WAIT_DONE->IDLE on tx_busy=0.
REQ-020 SHALL keep tx_data stable from LAUNCH until the return to IDLE.
REQ-021 SHALL apply simultaneous accepted push and pop in one cycle, leaving level unchanged.
REQ-022 SHALL meet a latency of: word written at edge k into an empty queue with FSM in IDLE and tx_busy=0 -> tx_start=1 in the cycle after edge k+1.
REQ-023 SHALL update full, empty and level on the same edge as the push/pop that changes them.
REQ-024 SHALL never launch while tx_busy=1; back-to-back words are separated by at least one IDLE cycle.

Reset
REQ-025 SHALL on rst=1 at a clock edge clear pointers and level, set state=IDLE, empty=1, full=0, level=0, overflow=0, tx_start=0, tx_data=0, timeout_err=0.
REQ-026 SHALL on reset mid-operation (any state) discard all queued and in-flight words, with no tx_start pulse until a new write occurs after reset.

Configuration
REQ-027 SHALL, with UART_TXQ_TIMEOUT_EN defined, count cycles in WAIT_BUSY; after START_TIMEOUT cycles with tx_busy=0, pulse timeout_err, discard the popped word and go to IDLE.
REQ-028 SHALL, without UART_TXQ_TIMEOUT_EN, wait in WAIT_BUSY indefinitely, tie timeout_err to 0 and keep the port present.

Structure
REQ-029 SHALL take UART_DATA_W=32 and the txq FSM state enum from shared package uart_pkg.
REQ-030 SHALL place storage, pointers and level in sub-module uart_sync_fifo, with the FSM kept in uart_tx_queue.

Verification
REQ-031 SHALL cover single word: write 32'hA5A5A5A5, model tx_busy high 3 cycles after start for 20 cycles -> exactly one tx_start, tx_data=A5A5A5A5, empty=1 at end.
REQ-032 SHALL cover burst order: write 8'h01..8'h08 (zero-extended) on consecutive cycles -> tx_data sequence 1..8, full=1 after 8th write if no pop yet.
REQ-033 SHALL cover overflow: fill DEPTH=8 with tx_busy=1 held, then 9th write of 32'h12345678 -> overflow pulse, level=8, word never appears on tx_data.
REQ-034 SHALL cover wrap: push/pop 20 words 32'h0..32'h13 -> all 20 emitted in order, level returns to 0.
REQ-035 SHALL cover timeout with UART_TXQ_TIMEOUT_EN: tx_busy stuck 0 -> timeout_err pulse 16 cycles after WAIT_BUSY entry, next word launches.
REQ-036 SHALL cover reset mid-WAIT_DONE with 3 words queued -> level=0, empty=1, no tx_start for 50 cycles.
